// File: rtl/niosii_irq_aggregator_pkg.sv
// rtl/niosii_irq_aggregator_pkg.sv - register map constants for the irq aggregator
package niosii_irq_aggregator_pkg;

  localparam logic [2:0] IRQ_PENDING = 3'd0;
  localparam logic [2:0] IRQ_MASK    = 3'd1;
  localparam logic [2:0] IRQ_MODE    = 3'd2;
  localparam logic [2:0] IRQ_ACTIVE  = 3'd3;
  localparam logic [2:0] IRQ_VECTOR  = 3'd4;
  localparam logic [2:0] IRQ_GEN     = 3'd5;

  // Position of the valid flag in the VECTOR register
  localparam int VEC_VALID_BIT = 15;

endpackage

// File: rtl/niosii_irq_aggregator_src_cell.sv
// rtl/niosii_irq_aggregator_src_cell.sv - per-source synchroniser, history and pending latch
module irq_src_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic irq_in,
  input  logic mode,     // 1 = rising-edge latch, 0 = level follow
  input  logic to_edge,  // MODE write switching this source from level to edge
  input  logic w1c,
  input  logic claim,
  output logic pending
);

  logic s;
  logic h;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_in;
    end else if (SYNC_STAGES == 1) begin : g_sync1
      logic sync_q;
      // single-flop sampler
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 1'b0;
        else          sync_q <= irq_in;
      end
      assign s = sync_q;
    end else begin : g_syncn
      logic [SYNC_STAGES-1:0] sync_q;
      // multi-flop synchroniser chain, irq_in enters at bit 0
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // history and pending; a new edge outranks clear requests in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h       <= 1'b0;
      pending <= 1'b0;
    end else begin
      h <= s;
      if (to_edge)
        pending <= 1'b0;
      else if (mode)
        pending <= (s & ~h) | (pending & ~(w1c | claim));
      else
        pending <= s;
    end
  end

endmodule

// File: rtl/niosii_irq_aggregator.sv
// rtl/niosii_irq_aggregator.sv - Avalon-MM interrupt aggregator with claimable vector
module niosii_irq_aggregator
  import niosii_irq_aggregator_pkg::*;
#(
  parameter int NUM_SRC     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  logic               wr_en;
  logic               rd_en;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] mode_q;
  logic               gen_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] to_edge;
  logic [NUM_SRC-1:0] claim;
  logic [3:0]         vec_idx;
  logic               vec_valid;
  logic [15:0]        vector_word;
  logic [15:0]        rd_mux;

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign active    = pending & mask_q;
  assign vec_valid = |active;

  assign w1c     = (wr_en && address == IRQ_PENDING) ? writedata[NUM_SRC-1:0] : '0;
  assign to_edge = (wr_en && address == IRQ_MODE) ? (writedata[NUM_SRC-1:0] & ~mode_q) : '0;
  // lowest set ACTIVE bit isolated as a one-hot; empty when nothing is active
  assign claim   = (rd_en && address == IRQ_VECTOR) ? (active & (~active + NUM_SRC'(1))) : '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_src_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (irq_in[g]),
      .mode    (mode_q[g]),
      .to_edge (to_edge[g]),
      .w1c     (w1c[g]),
      .claim   (claim[g]),
      .pending (pending[g])
    );
  end

  // fixed-priority encoder, bit 0 wins
  always_comb begin
    vec_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) vec_idx = 4'(i);
    end
    vector_word                = '0;
    vector_word[VEC_VALID_BIT] = vec_valid;
    vector_word[3:0]           = vec_idx;
  end

  // read mux over the current (pre-claim) state
  always_comb begin
    rd_mux = '0;
    case (address)
      IRQ_PENDING: rd_mux = 16'(pending);
      IRQ_MASK:    rd_mux = 16'(mask_q);
      IRQ_MODE:    rd_mux = 16'(mode_q);
      IRQ_ACTIVE:  rd_mux = 16'(active);
      IRQ_VECTOR:  rd_mux = vector_word;
      IRQ_GEN:     rd_mux = {15'b0, gen_q};
      default:     rd_mux = '0;
    endcase
  end

  // control register writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      mode_q <= '0;
      gen_q  <= 1'b0;
    end else if (wr_en) begin
      case (address)
        IRQ_MASK: mask_q <= writedata[NUM_SRC-1:0];
        IRQ_MODE: mode_q <= writedata[NUM_SRC-1:0];
        IRQ_GEN:  gen_q  <= writedata[0];
        default:  ;
      endcase
    end
  end

  // registered outputs: read data every cycle, irq from gated active set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_mux;
      irq      <= gen_q & vec_valid;
    end
  end

endmodule

// File: tb/tb_niosii_irq_aggregator.sv
// tb/tb_niosii_irq_aggregator.sv - directed bench for the irq aggregator
module tb_niosii_irq_aggregator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [15:0] irq_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[26];

  niosii_irq_aggregator #(.NUM_SRC(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic [15:0] rd;

    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 3'd1, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 3'd3, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 3'd4, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 3'd5, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 3'd6, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b0, 3'd7, 16'h0000, 16'h0000};
    vecs[8]  = '{1'b1, 3'd1, 16'hABCD, 16'h0000};
    vecs[9]  = '{1'b0, 3'd1, 16'h0000, 16'hABCD};
    vecs[10] = '{1'b1, 3'd2, 16'h1234, 16'h0000};
    vecs[11] = '{1'b0, 3'd2, 16'h0000, 16'h1234};
    vecs[12] = '{1'b1, 3'd5, 16'hFFFF, 16'h0000};
    vecs[13] = '{1'b0, 3'd5, 16'h0000, 16'h0001};
    vecs[14] = '{1'b1, 3'd3, 16'hFFFF, 16'h0000};
    vecs[15] = '{1'b0, 3'd3, 16'h0000, 16'h0000};
    vecs[16] = '{1'b0, 3'd0, 16'h0000, 16'h0000};
    vecs[17] = '{1'b0, 3'd4, 16'h0000, 16'h0000};
    vecs[18] = '{1'b1, 3'd6, 16'hFFFF, 16'h0000};
    vecs[19] = '{1'b0, 3'd6, 16'h0000, 16'h0000};
    vecs[20] = '{1'b1, 3'd1, 16'h0000, 16'h0000};
    vecs[21] = '{1'b1, 3'd2, 16'h0000, 16'h0000};
    vecs[22] = '{1'b1, 3'd5, 16'h0000, 16'h0000};
    vecs[23] = '{1'b0, 3'd1, 16'h0000, 16'h0000};
    vecs[24] = '{1'b0, 3'd2, 16'h0000, 16'h0000};
    vecs[25] = '{1'b0, 3'd5, 16'h0000, 16'h0000};

    reset_n = 1'b0; address = '0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = '0; irq_in = '0;
    idle(3);
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);
    reset_n = 1'b1;

    // register map sweep
    for (int i = 0; i < 26; i++) begin
      if (vecs[i].wr) begin
        wr_reg(vecs[i].addr, vecs[i].data);
      end else begin
        rd_reg(vecs[i].addr, rd);
        check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end
    check("sweep_irq", {15'b0, irq}, 16'h0000);

    // edge latency and W1C
    wr_reg(3'd1, 16'h0001);
    wr_reg(3'd2, 16'h0001);
    wr_reg(3'd5, 16'h0001);
    @(negedge clk); irq_in = 16'h0001;
    @(negedge clk); irq_in = 16'h0000;
    check("edge_irq_k", {15'b0, irq}, 16'h0000);
    @(negedge clk); check("edge_irq_k1", {15'b0, irq}, 16'h0000);
    @(negedge clk); check("edge_irq_k2", {15'b0, irq}, 16'h0000);
    @(negedge clk); check("edge_irq_k3", {15'b0, irq}, 16'h0001);
    rd_reg(3'd0, rd);
    check("edge_pending", rd, 16'h0001);
    wr_reg(3'd0, 16'h0001);
    check("w1c_irq_w", {15'b0, irq}, 16'h0001);
    @(negedge clk); check("w1c_irq_w1", {15'b0, irq}, 16'h0000);

    // level mode
    wr_reg(3'd2, 16'h0000);
    wr_reg(3'd1, 16'h0004);
    irq_in = 16'h0004;
    idle(4);
    check("level_irq", {15'b0, irq}, 16'h0001);
    wr_reg(3'd0, 16'h0004);
    rd_reg(3'd0, rd);
    check("level_w1c_ignored", rd, 16'h0004);
    irq_in = 16'h0000;
    @(negedge clk); check("level_drop_k", {15'b0, irq}, 16'h0001);
    @(negedge clk); check("level_drop_k1", {15'b0, irq}, 16'h0001);
    @(negedge clk); check("level_drop_k2", {15'b0, irq}, 16'h0001);
    @(negedge clk); check("level_drop_k3", {15'b0, irq}, 16'h0000);

    // priority and claim
    wr_reg(3'd2, 16'h0028);
    wr_reg(3'd1, 16'hFFFF);
    @(negedge clk); irq_in = 16'h0028;
    @(negedge clk); irq_in = 16'h0000;
    idle(4);
    check("claim_irq_before", {15'b0, irq}, 16'h0001);
    rd_reg(3'd4, rd); check("claim_vec1", rd, 16'h8003);
    rd_reg(3'd4, rd); check("claim_vec2", rd, 16'h8005);
    rd_reg(3'd4, rd); check("claim_vec3", rd, 16'h0000);
    @(negedge clk); check("claim_irq_after", {15'b0, irq}, 16'h0000);

    // set/clear collision on bit 0
    wr_reg(3'd2, 16'h0001);
    @(negedge clk); irq_in = 16'h0001;
    @(negedge clk); irq_in = 16'h0000;
    @(negedge clk);
    address = 3'd0; writedata = 16'h0001; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    rd_reg(3'd0, rd); check("collision_pending", rd, 16'h0001);
    wr_reg(3'd0, 16'h0001);
    rd_reg(3'd0, rd); check("collision_cleared", rd, 16'h0000);

    // masked latch, unmask, async reset
    wr_reg(3'd1, 16'h0000);
    wr_reg(3'd2, 16'h0002);
    @(negedge clk); irq_in = 16'h0002;
    @(negedge clk); irq_in = 16'h0000;
    idle(4);
    check("masked_irq", {15'b0, irq}, 16'h0000);
    rd_reg(3'd0, rd); check("masked_pending", rd, 16'h0002);
    wr_reg(3'd1, 16'h0002);
    check("unmask_irq_w", {15'b0, irq}, 16'h0000);
    @(negedge clk); check("unmask_irq_w1", {15'b0, irq}, 16'h0001);
    #2 reset_n = 1'b0;
    #1 check("async_reset_irq", {15'b0, irq}, 16'h0000);
    check("async_reset_readdata", readdata, 16'h0000);
    @(negedge clk); reset_n = 1'b1;
    rd_reg(3'd0, rd); check("post_reset_pending", rd, 16'h0000);
    rd_reg(3'd1, rd); check("post_reset_mask", rd, 16'h0000);
    @(negedge clk); check("post_reset_irq", {15'b0, irq}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
